// File: rtl/seq_multiplier_param.sv
// Iterative shift-and-add multiplier, signed or unsigned per operation.
// It retires BITS_PER_CYCLE multiplier bits on each RUN cycle and negates the magnitude product at the end.
module seq_multiplier_param #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             sign_mode,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] multiplicand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product_lo,
  output logic [WIDTH-1:0] product_hi
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CW    = $clog2(STEPS + 1);
  localparam int PW    = 2 * WIDTH;

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4) ||
        (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_param
      $error("seq_multiplier_param: illegal WIDTH/BITS_PER_CYCLE combination");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [WIDTH-1:0]  r_mplier;
  logic [PW-1:0]     r_mcand;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_prod;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic              r_done;

  logic              w_accept;
  logic              w_last;
  logic [WIDTH-1:0]  w_mag_a;
  logic [WIDTH-1:0]  w_mag_b;
  logic [PW-1:0]     w_acc_next;
  logic [PW-1:0]     w_result;
  logic [PW-1:0]     w_terms [BITS_PER_CYCLE];

  assign w_accept = (r_state == S_IDLE) && start && !abort;
  assign w_last   = (r_cnt == CW'(1));

  // Two's complement of the most negative value wraps to 2^(WIDTH-1), which is the correct magnitude.
  assign w_mag_a = (sign_mode && multiplier[WIDTH-1])   ? (~multiplier + WIDTH'(1))   : multiplier;
  assign w_mag_b = (sign_mode && multiplicand[WIDTH-1]) ? (~multiplicand + WIDTH'(1)) : multiplicand;

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      assign w_terms[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
    end
  endgenerate

  always_comb begin
    w_acc_next = r_acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_acc_next = w_acc_next + w_terms[i];
    end
  end

  assign w_result = r_neg ? (~w_acc_next + PW'(1)) : w_acc_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_RUN;
      S_RUN:   if (abort || w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_mplier <= w_mag_a;
        r_mcand  <= {{WIDTH{1'b0}}, w_mag_b};
        r_acc    <= '0;
        r_cnt    <= CW'(STEPS);
        r_neg    <= sign_mode & (multiplier[WIDTH-1] ^ multiplicand[WIDTH-1]);
      end else if (r_state == S_RUN && !abort) begin
        r_acc    <= w_acc_next;
        r_mplier <= r_mplier >> BITS_PER_CYCLE;
        r_mcand  <= r_mcand << BITS_PER_CYCLE;
        r_cnt    <= r_cnt - CW'(1);
        // The result register is written only at the last step, so partial sums never reach the outputs.
        if (w_last) begin
          r_prod <= w_result;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy       = (r_state == S_RUN);
  assign done       = r_done;
  assign product_lo = r_prod[WIDTH-1:0];
  assign product_hi = r_prod[PW-1:WIDTH];

endmodule
